cutoff_update_sequencer: RTL and testbench
==========================================

// Module: cutoff_update_sequencer
// PURPOSE
//   Sequences cutoff-frequency updates from the envelope follower to the filter core.
//   Decimates env_avg strobes and normalises env_avg with a shared multi-cycle divider.
//   Applies the strength control, clamps to [FC_MIN_DIGITAL, FC_MAX_DIGITAL] and slew-limits.
//   Hands each new Q8.16 cutoff to the filter over a valid/ready port.
// PARAMETERS
//   SAMPLE_WIDTH    24          sample and cutoff word width
//   FC_MIN_DIGITAL  24'h00035a  200 Hz digital cutoff; also the reset value of fc_out
//   FC_MAX_DIGITAL  24'h014f1a  20 kHz digital cutoff
//   TYPICAL_ENV     1_000_000   env_avg that maps to full scale (Q16 1.0)
//   SLEW_STEP       24'h000400  max |delta| of fc_out per transaction; 0 = no limit
//   UPDATE_DIV      16          one computation per UPDATE_DIV accepted env strobes (>=1)
// PORTS
//   clk                    in   1   clock
//   rst_n                  in   1   synchronous reset, active low
//   env_valid              in   1   one-cycle strobe: env_avg holds a new value
//   env_avg                in   24  envelope average, unsigned
//   filter_strength_ratio  in   4   control value 0..15; 0 forces FC_MIN_DIGITAL
//   fc_valid               out  1   fc_out holds a new cutoff
//   fc_ready               in   1   filter accepts fc_out when fc_valid & fc_ready
//   fc_out                 out  24  current cutoff, Q8.16
//   busy                   out  1   high in any state other than IDLE
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): state IDLE, fc_valid 0, busy 0, fc_out FC_MIN_DIGITAL.
//     Decimation counter cleared; any divide in progress is abandoned.
//   Decimation: env_valid is counted only in IDLE; it is ignored (not counted) while busy.
//     The UPDATE_DIV-th counted strobe is the trigger; the counter returns to 0.
//     On the trigger edge, env_avg and filter_strength_ratio are latched.
//     Later input changes do not affect the update in flight.
//   FSM: IDLE -> DIVIDE (17 cycles) -> SCALE -> SLEW -> OFFER -> IDLE.
//     Fast path IDLE -> SCALE applies when strength==0 or env_avg>=TYPICAL_ENV.
//     For the fast path, env_scaled=65536; the strength==0 result is forced in SCALE.
//   DIVIDE: restoring divider, one quotient bit per cycle.
//     env_scaled = floor(env_avg*65536/TYPICAL_ENV), 17 bits, <=65536.
//   SCALE: controlled = (env_scaled*(s+1))>>4.
//     target = FC_MIN_DIGITAL + ((controlled*FC_RANGE)>>16), with FC_RANGE=MAX-MIN.
//     Use >=48-bit intermediates; no truncation before the shift.
//     target is clamped to [MIN,MAX]. s==0 gives target=FC_MIN_DIGITAL.
//   SLEW (SLEW_STEP!=0):
//     next = target>fc_out+STEP ? fc_out+STEP : target<fc_out-STEP ? fc_out-STEP : target.
//     No wrap: fc_out-STEP below MIN saturates to MIN.
//     If next==fc_out, the update is dropped: go to IDLE with no transaction.
//   OFFER: fc_out<=next and fc_valid<=1 on entry.
//     fc_out and fc_valid are held stable until fc_valid&fc_ready.
//     Transfer happens on that edge; then fc_valid 0 and state IDLE.
//     fc_ready while fc_valid is low has no effect.
//   Latency: fc_valid is high in cycle 20 after the trigger edge (full path).
//     Fast path: cycle 3. Zero-wait fc_ready gives back-to-back readiness in IDLE next cycle.
//   fc_out changes only on OFFER entry or reset; it is never X and never outside [MIN,MAX].
// STRUCTURE
//   Package cutoff_pkg: seq_state_e enum (IDLE, DIVIDE, SCALE, SLEW, OFFER).
//     Also: Q16_ONE=17'd65536, FC_MIN/MAX_DIGITAL, FC_RANGE localparam, DIV_CYCLES=17.
//   Sub-module seq_divider: start/done restoring unsigned divider.
//     Dividend 41 bits (env<<16), divisor TYPICAL_ENV, 17-bit quotient.
//     It is synchronously reset by rst_n.
//   Top level: FSM, decimation counter, scale/clamp/slew datapath, output registers.
// TESTING
//   1 Reset, then idle 10 cycles: fc_out==24'h00035a, fc_valid==0, busy==0 throughout.
//   2 UPDATE_DIV=1, SLEW_STEP=0, s=15, env=500_000, fc_ready=1:
//     fc_valid rises in cycle 20 with fc_out==24'h00a93a, 1 cycle wide.
//   3 UPDATE_DIV=1, SLEW_STEP=0x400, s=15, env=2_000_000:
//     fast path, fc_valid in cycle 3, fc_out==24'h00075a.
//     Repeat to reach 24'h014f1a with no overshoot.
//   4 Case 2 with fc_ready=0 for 7 cycles plus env_valid pulses during OFFER:
//     fc_out stable, one transfer, strobes not counted, no second update.
//   5 UPDATE_DIV=4, 8 strobes spaced 30 cycles apart:
//     exactly 2 transactions, on strobes 4 and 8. s=0 after reset: no transaction (next==fc_out).
//   6 rst_n low for 1 cycle in DIVIDE cycle 8: reset values next cycle.
//     No fc_valid until a fresh trigger; the next result matches the golden model.

Source files
------------

// File: rtl/cutoff_pkg.sv
// ---------------------------------------------------------------------------
// cutoff_pkg
//   Shared types and constants for the cutoff update sequencer.
//   seq_state_e : sequencer FSM states
//   Q16_ONE     : 1.0 in the Q16 normalised envelope domain
//   FC_*        : digital cutoff limits (Q8.16) and their span
//   TYPICAL_ENV : envelope average that maps to full scale
//   DIV_CYCLES  : quotient bits produced by the divider, one per cycle
// ---------------------------------------------------------------------------
package cutoff_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DIVIDE,
      SCALE,
      SLEW,
      OFFER
   } seq_state_e;

   localparam logic [16:0] Q16_ONE        = 17'd65536;
   localparam logic [23:0] FC_MIN_DIGITAL = 24'h00035a;
   localparam logic [23:0] FC_MAX_DIGITAL = 24'h014f1a;
   localparam logic [23:0] FC_RANGE       = FC_MAX_DIGITAL - FC_MIN_DIGITAL;
   localparam int unsigned TYPICAL_ENV    = 1_000_000;
   localparam int unsigned DIV_CYCLES     = 17;

endpackage

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Restoring unsigned divider with a constant divisor, one quotient bit per
//   cycle. A start pulse loads the dividend; Q_W cycles later done is high
//   for the cycle whose closing edge writes the last quotient bit, so the
//   quotient is complete from the following cycle and is held until the
//   next start.
//   The quotient must fit in Q_W bits (dividend < DIVISOR << Q_W).
// Ports
//   clk, rst_n   clock, synchronous active-low reset (abandons a divide)
//   start        one-cycle pulse: latch dividend and begin
//   dividend     DIVIDEND_W-bit unsigned dividend
//   quotient     Q_W-bit quotient register
//   done         high in the last step cycle
// ---------------------------------------------------------------------------
module seq_divider
   import cutoff_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = 41,
   parameter int unsigned Q_W        = DIV_CYCLES,
   parameter int unsigned DIVISOR    = TYPICAL_ENV
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   output logic [Q_W-1:0]        quotient,
   output logic                  done
);

   // The partial remainder stays below DIVISOR, so it never needs more bits
   // than the part of the dividend above the quotient window.
   localparam int unsigned REM_W = DIVIDEND_W - Q_W;
   localparam int unsigned CNT_W = $clog2(Q_W + 1);
   localparam logic [REM_W:0] DIVISOR_T = (REM_W + 1)'(DIVISOR);

   logic [REM_W-1:0] rem_q;
   logic [Q_W-1:0]   low_q;
   logic [Q_W-1:0]   quo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;
   logic [REM_W:0]   trial;

   always_comb trial = {rem_q, low_q[Q_W-1]};

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         rem_q <= '0;
         low_q <= '0;
         quo_q <= '0;
      end else if (start) begin
         // High dividend bits seed the remainder; the low Q_W bits are
         // shifted in one per step.
         rem_q <= REM_W'(dividend >> Q_W);
         low_q <= dividend[Q_W-1:0];
         quo_q <= '0;
         cnt_q <= CNT_W'(Q_W);
         run_q <= 1'b1;
      end else if (run_q) begin
         if (trial >= DIVISOR_T) begin
            rem_q <= REM_W'(trial - DIVISOR_T);
            quo_q <= {quo_q[Q_W-2:0], 1'b1};
         end else begin
            rem_q <= REM_W'(trial);
            quo_q <= {quo_q[Q_W-2:0], 1'b0};
         end
         low_q <= low_q << 1;
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
      end
   end

   assign done     = run_q && (cnt_q == CNT_W'(1));
   assign quotient = quo_q;

endmodule

// File: rtl/cutoff_update_sequencer.sv
// ---------------------------------------------------------------------------
// cutoff_update_sequencer
//   Turns decimated envelope-average strobes into slew-limited Q8.16 cutoff
//   updates for the filter core.
//   IDLE -> DIVIDE (17 cycles) -> SCALE -> SLEW -> OFFER -> IDLE, with a
//   fast path IDLE -> SCALE when strength is 0 or the envelope is at or
//   above full scale. An update whose slewed value equals the current
//   cutoff is dropped in SLEW.
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   env_valid, env_avg     envelope strobe and unsigned average
//   filter_strength_ratio  0..15, 0 forces the minimum cutoff
//   fc_valid, fc_ready     output handshake; transfer on valid & ready
//   fc_out                 current cutoff, held while fc_valid is high
//   busy                   FSM not in IDLE
// ---------------------------------------------------------------------------
module cutoff_update_sequencer #(
   parameter int unsigned                SAMPLE_WIDTH   = 24,
   parameter logic [SAMPLE_WIDTH-1:0]    FC_MIN_DIGITAL = cutoff_pkg::FC_MIN_DIGITAL,
   parameter logic [SAMPLE_WIDTH-1:0]    FC_MAX_DIGITAL = cutoff_pkg::FC_MAX_DIGITAL,
   parameter int unsigned                TYPICAL_ENV    = cutoff_pkg::TYPICAL_ENV,
   parameter logic [SAMPLE_WIDTH-1:0]    SLEW_STEP      = 24'h000400,
   parameter int unsigned                UPDATE_DIV     = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    env_valid,
   input  logic [SAMPLE_WIDTH-1:0] env_avg,
   input  logic [3:0]              filter_strength_ratio,
   output logic                    fc_valid,
   input  logic                    fc_ready,
   output logic [SAMPLE_WIDTH-1:0] fc_out,
   output logic                    busy
);

   import cutoff_pkg::seq_state_e;
   import cutoff_pkg::IDLE;
   import cutoff_pkg::DIVIDE;
   import cutoff_pkg::SCALE;
   import cutoff_pkg::SLEW;
   import cutoff_pkg::OFFER;
   import cutoff_pkg::Q16_ONE;
   import cutoff_pkg::DIV_CYCLES;

   localparam int unsigned SW         = SAMPLE_WIDTH;
   localparam int unsigned DIVIDEND_W = SW + 17;
   localparam int unsigned DEC_W      = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam logic [SW-1:0] FC_SPAN   = FC_MAX_DIGITAL - FC_MIN_DIGITAL;
   localparam logic [SW-1:0] TYPICAL_W = SW'(TYPICAL_ENV);

   seq_state_e state_q, state_d;

   logic [DEC_W-1:0] dec_cnt_q;
   logic [3:0]       strength_q;
   logic             fast_q;
   logic [SW-1:0]    target_q;
   logic [SW-1:0]    fc_out_q;

   logic             trigger;
   logic             fast_now;
   logic             div_done;
   logic [16:0]      div_quotient;

   logic [16:0]      env_scaled;
   logic [47:0]      ctl_prod, controlled, range_prod, target_sum;
   logic [SW-1:0]    target_next;

   logic [SW:0]      up_sum, min_plus_step;
   logic [SW-1:0]    down_val, slew_next;

   // Strobes are counted only while idle; the UPDATE_DIV-th one triggers.
   assign trigger  = (state_q == IDLE) && env_valid &&
                     (dec_cnt_q == DEC_W'(UPDATE_DIV - 1));
   assign fast_now = (filter_strength_ratio == 4'd0) || (env_avg >= TYPICAL_W);

   // The divider latches env_avg itself on the trigger edge, so the update in
   // flight is immune to later input changes.
   seq_divider #(
      .DIVIDEND_W (DIVIDEND_W),
      .Q_W        (DIV_CYCLES),
      .DIVISOR    (TYPICAL_ENV)
   ) u_divider (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (trigger && !fast_now),
      .dividend ({1'b0, env_avg, 16'h0000}),
      .quotient (div_quotient),
      .done     (div_done)
   );

   // Strength scaling and range mapping, full-width before each shift.
   always_comb begin
      env_scaled  = fast_q ? Q16_ONE : div_quotient;
      ctl_prod    = 48'(env_scaled) * 48'({1'b0, strength_q} + 5'd1);
      controlled  = ctl_prod >> 4;
      range_prod  = controlled * 48'(FC_SPAN);
      target_sum  = 48'(FC_MIN_DIGITAL) + (range_prod >> 16);
      target_next = SW'(target_sum);
      if (strength_q == 4'd0)                    target_next = FC_MIN_DIGITAL;
      else if (target_sum > 48'(FC_MAX_DIGITAL)) target_next = FC_MAX_DIGITAL;
      else if (target_sum < 48'(FC_MIN_DIGITAL)) target_next = FC_MIN_DIGITAL;
   end

   // Slew limiting; the downward bound saturates at the minimum cutoff
   // instead of wrapping.
   always_comb begin
      up_sum        = {1'b0, fc_out_q} + {1'b0, SLEW_STEP};
      min_plus_step = {1'b0, FC_MIN_DIGITAL} + {1'b0, SLEW_STEP};
      down_val      = FC_MIN_DIGITAL;
      if ({1'b0, fc_out_q} >= min_plus_step) down_val = fc_out_q - SLEW_STEP;
      slew_next = target_q;
      if (SLEW_STEP != '0) begin
         if ({1'b0, target_q} > up_sum) slew_next = SW'(up_sum);
         else if (target_q < down_val)  slew_next = down_val;
      end
   end

   // NOTE: state_d gets its default before the case so that every path
   // assigns it and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (trigger) state_d = fast_now ? SCALE : DIVIDE;
         DIVIDE:  if (div_done) state_d = SCALE;
         SCALE:   state_d = SLEW;
         SLEW:    state_d = (slew_next == fc_out_q) ? IDLE : OFFER;
         OFFER:   if (fc_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dec_cnt_q  <= '0;
         strength_q <= '0;
         fast_q     <= 1'b0;
         target_q   <= FC_MIN_DIGITAL;
         fc_out_q   <= FC_MIN_DIGITAL;
      end else begin
         state_q <= state_d;

         if (trigger) begin
            dec_cnt_q  <= '0;
            strength_q <= filter_strength_ratio;
            fast_q     <= fast_now;
         end else if ((state_q == IDLE) && env_valid) begin
            dec_cnt_q <= dec_cnt_q + 1'b1;
         end

         if (state_q == SCALE) target_q <= target_next;

         // fc_out only moves on entry to OFFER and is then held until the
         // transfer.
         if ((state_q == SLEW) && (state_d == OFFER)) fc_out_q <= slew_next;
      end
   end

   assign fc_valid = (state_q == OFFER);
   assign busy     = (state_q != IDLE);
   assign fc_out   = fc_out_q;

endmodule

// File: tb/tb_cutoff_update_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cutoff_update_sequencer
//   Three sequencer instances share clk/rst_n:
//     [0] UPDATE_DIV=1, SLEW_STEP=0       (full-path latency, backpressure, reset)
//     [1] UPDATE_DIV=1, SLEW_STEP=0x400   (fast path, slew ramp)
//     [2] UPDATE_DIV=4, SLEW_STEP=0x400   (decimation)
//   Expected cutoffs come from an arithmetic model of the mapping rules.
// ---------------------------------------------------------------------------
module tb_cutoff_update_sequencer;

   localparam int unsigned MIN   = 32'h00035a;
   localparam int unsigned MAX   = 32'h014f1a;
   localparam int unsigned RANGE = MAX - MIN;
   localparam int unsigned T_ENV = 1_000_000;

   logic        clk;
   logic        rst_n;
   logic        env_valid [3];
   logic [23:0] env_avg   [3];
   logic [3:0]  strength  [3];
   logic        fc_ready  [3];
   logic        fc_valid  [3];
   logic [23:0] fc_out    [3];
   logic        busy      [3];

   int unsigned fc_model [3];
   int          n_checks = 0;
   int          n_fail   = 0;

   cutoff_update_sequencer #(
      .SAMPLE_WIDTH(24), .FC_MIN_DIGITAL(24'h00035a), .FC_MAX_DIGITAL(24'h014f1a),
      .TYPICAL_ENV(1_000_000), .SLEW_STEP(24'h000000), .UPDATE_DIV(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .env_valid(env_valid[0]), .env_avg(env_avg[0]),
      .filter_strength_ratio(strength[0]), .fc_valid(fc_valid[0]),
      .fc_ready(fc_ready[0]), .fc_out(fc_out[0]), .busy(busy[0])
   );

   cutoff_update_sequencer #(
      .SAMPLE_WIDTH(24), .FC_MIN_DIGITAL(24'h00035a), .FC_MAX_DIGITAL(24'h014f1a),
      .TYPICAL_ENV(1_000_000), .SLEW_STEP(24'h000400), .UPDATE_DIV(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .env_valid(env_valid[1]), .env_avg(env_avg[1]),
      .filter_strength_ratio(strength[1]), .fc_valid(fc_valid[1]),
      .fc_ready(fc_ready[1]), .fc_out(fc_out[1]), .busy(busy[1])
   );

   cutoff_update_sequencer #(
      .SAMPLE_WIDTH(24), .FC_MIN_DIGITAL(24'h00035a), .FC_MAX_DIGITAL(24'h014f1a),
      .TYPICAL_ENV(1_000_000), .SLEW_STEP(24'h000400), .UPDATE_DIV(4)
   ) dut_c (
      .clk(clk), .rst_n(rst_n), .env_valid(env_valid[2]), .env_avg(env_avg[2]),
      .filter_strength_ratio(strength[2]), .fc_valid(fc_valid[2]),
      .fc_ready(fc_ready[2]), .fc_out(fc_out[2]), .busy(busy[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int unsigned step_of(input int d);
      return (d == 0) ? 0 : 32'h400;
   endfunction

   function automatic int unsigned model_target(input int unsigned env, input int unsigned s);
      longint unsigned frac, ctl, t;
      if (s == 0) return MIN;
      if (env >= T_ENV) frac = 65536;
      else              frac = (64'(env) * 64'd65536) / 64'(T_ENV);
      ctl = (frac * 64'(s + 1)) / 16;
      t   = 64'(MIN) + (ctl * 64'(RANGE)) / 65536;
      if (t > 64'(MAX)) t = 64'(MAX);
      return 32'(t);
   endfunction

   function automatic int unsigned model_slew(input int unsigned cur, input int unsigned tgt,
                                              input int unsigned step);
      longint lo;
      if (step == 0) return tgt;
      if (longint'(tgt) > longint'(cur) + longint'(step)) return cur + step;
      lo = longint'(cur) - longint'(step);
      if (lo < longint'(MIN)) lo = longint'(MIN);
      if (longint'(tgt) < lo) return 32'(lo);
      return tgt;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One env strobe; the trigger edge is the posedge inside this task. Inputs
   // are scrambled right after, so the update must use the latched values.
   // Returns at the negedge of cycle 1 after that edge.
   task automatic pulse(input int d, input int unsigned env, input int unsigned s);
      @(negedge clk);
      env_avg[d]   = 24'(env);
      strength[d]  = 4'(s);
      env_valid[d] = 1'b1;
      @(negedge clk);
      env_valid[d] = 1'b0;
      env_avg[d]   = 24'($urandom);
      strength[d]  = 4'($urandom);
   endtask

   // Cycle number (1 = first cycle after the trigger edge) in which fc_valid
   // is first seen; limit if it never rises.
   task automatic wait_valid(input int d, input int limit, output int cyc);
      cyc = 1;
      while (fc_valid[d] !== 1'b1 && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic expect_no_valid(input int d, input int cycles, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         if (fc_valid[d] !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      check({tag, "_no_valid"}, 32'(seen), 32'd0);
      check({tag, "_idle"}, 32'(busy[d]), 32'd0);
   endtask

   task automatic strobe_and_watch(input int d, input int unsigned env, input int unsigned s,
                                   input int window, output logic seen, output logic [23:0] val);
      pulse(d, env, s);
      seen = 1'b0;
      val  = '0;
      for (int w = 0; w < window; w++) begin
         if (fc_valid[d] === 1'b1 && !seen) begin
            seen = 1'b1;
            val  = fc_out[d];
         end
         @(negedge clk);
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int          cyc;
      int          txn;
      int          delay;
      int          d;
      logic        seen;
      logic        stable;
      logic [23:0] val;
      int unsigned env, s, tgt, nxt, pick;

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         env_valid[i] = 1'b0;
         env_avg[i]   = '0;
         strength[i]  = '0;
         fc_ready[i]  = 1'b0;
         fc_model[i]  = MIN;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1: reset state held through 10 idle cycles
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_fc_out[%0d]", i), 32'(fc_out[i]), MIN);
            check($sformatf("t1_fc_valid[%0d]", i), 32'(fc_valid[i]), 32'd0);
            check($sformatf("t1_busy[%0d]", i), 32'(busy[i]), 32'd0);
         end
      end
      for (int i = 0; i < 3; i++) fc_ready[i] = 1'b1;

      // 2: full path, zero-wait ready
      pulse(0, 500_000, 15);
      check("t2_busy", 32'(busy[0]), 32'd1);
      wait_valid(0, 30, cyc);
      check("t2_latency", 32'(cyc), 32'd20);
      check("t2_fc_out", 32'(fc_out[0]), 32'h00a93a);
      @(negedge clk);
      check("t2_valid_one_cycle", 32'(fc_valid[0]), 32'd0);
      check("t2_idle_after", 32'(busy[0]), 32'd0);
      fc_model[0] = 32'h00a93a;

      // 3: fast path with slew ramp to the maximum
      pulse(1, 2_000_000, 15);
      wait_valid(1, 10, cyc);
      check("t3_latency", 32'(cyc), 32'd3);
      check("t3_first_step", 32'(fc_out[1]), 32'h00075a);
      fc_model[1] = 32'h00075a;
      for (int i = 0; i < 100 && fc_model[1] != MAX; i++) begin
         pulse(1, 2_000_000, 15);
         wait_valid(1, 10, cyc);
         nxt = model_slew(fc_model[1], model_target(2_000_000, 15), step_of(1));
         check("t3_ramp", 32'(fc_out[1]), nxt);
         check("t3_no_overshoot", 32'(fc_out[1] <= 24'(MAX)), 32'd1);
         fc_model[1] = nxt;
      end
      check("t3_final_max", 32'(fc_out[1]), 32'h014f1a);
      pulse(1, 2_000_000, 15);
      expect_no_valid(1, 10, "t3_at_max_dropped");

      // 4: backpressure with strobes during OFFER
      fc_ready[0] = 1'b0;
      pulse(0, 250_000, 15);
      wait_valid(0, 30, cyc);
      check("t4_latency", 32'(cyc), 32'd20);
      check("t4_fc_out", 32'(fc_out[0]), 32'h00564a);
      stable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         env_valid[0] = (i % 2 == 0);
         env_avg[0]   = 24'd900_000;
         strength[0]  = 4'd15;
         @(negedge clk);
         if (fc_valid[0] !== 1'b1 || fc_out[0] !== 24'h00564a) stable = 1'b0;
      end
      check("t4_held_stable", 32'(stable), 32'd1);
      env_valid[0] = 1'b0;
      fc_ready[0]  = 1'b1;
      @(negedge clk);
      check("t4_transfer", 32'(fc_valid[0]), 32'd0);
      expect_no_valid(0, 40, "t4_no_second_update");
      check("t4_fc_out_kept", 32'(fc_out[0]), 32'h00564a);
      fc_model[0] = 32'h00564a;

      // 5: decimation by 4; strength 0 from reset is dropped
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         strobe_and_watch(2, 600_000, 0, 25, stable, val);
         if (stable) seen = 1'b1;
      end
      check("t5_s0_no_txn", 32'(seen), 32'd0);
      check("t5_s0_fc_out", 32'(fc_out[2]), MIN);
      txn = 0;
      for (int i = 1; i <= 8; i++) begin
         strobe_and_watch(2, 500_000, 15, 28, seen, val);
         check($sformatf("t5_txn_on_strobe%0d", i), 32'(seen), 32'(i % 4 == 0));
         if (seen) txn++;
         if (i % 4 == 0) begin
            nxt = model_slew(fc_model[2], model_target(500_000, 15), step_of(2));
            check($sformatf("t5_value_strobe%0d", i), 32'(val), nxt);
            fc_model[2] = nxt;
         end
      end
      check("t5_txn_count", 32'(txn), 32'd2);

      // 6: reset in DIVIDE cycle 8
      pulse(0, 750_000, 7);
      repeat (7) @(negedge clk);
      check("t6_in_divide", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t6_rst_fc_out[%0d]", i), 32'(fc_out[i]), MIN);
         check($sformatf("t6_rst_valid[%0d]", i), 32'(fc_valid[i]), 32'd0);
         check($sformatf("t6_rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
         fc_model[i] = MIN;
      end
      expect_no_valid(0, 30, "t6_abandoned");
      pulse(0, 750_000, 7);
      wait_valid(0, 30, cyc);
      check("t6_latency", 32'(cyc), 32'd20);
      nxt = model_slew(fc_model[0], model_target(750_000, 7), step_of(0));
      check("t6_fresh_result", 32'(fc_out[0]), nxt);
      fc_model[0] = nxt;
      @(negedge clk);

      // random transactions on the two UPDATE_DIV=1 instances
      for (int it = 0; it < 60; it++) begin
         d    = int'($urandom_range(0, 1));
         pick = $urandom_range(0, 9);
         if (pick == 0)      env = T_ENV;
         else if (pick == 1) env = T_ENV - 1;
         else if (pick == 2) env = 0;
         else                env = $urandom_range(0, 2_500_000);
         s     = $urandom_range(0, 15);
         delay = int'($urandom_range(0, 3));
         tgt   = model_target(env, s);
         nxt   = model_slew(fc_model[d], tgt, step_of(d));
         fc_ready[d] = 1'b0;
         pulse(d, env, s);
         if (nxt == fc_model[d]) begin
            expect_no_valid(d, 25, $sformatf("rnd%0d_drop", it));
         end else begin
            wait_valid(d, 25, cyc);
            check($sformatf("rnd%0d_latency", it), 32'(cyc),
                  (s == 0 || env >= T_ENV) ? 32'd3 : 32'd20);
            check($sformatf("rnd%0d_fc_out", it), 32'(fc_out[d]), nxt);
            stable = 1'b1;
            for (int w = 0; w < delay; w++) begin
               @(negedge clk);
               if (fc_valid[d] !== 1'b1 || fc_out[d] !== 24'(nxt)) stable = 1'b0;
            end
            check($sformatf("rnd%0d_hold", it), 32'(stable), 32'd1);
            fc_ready[d] = 1'b1;
            @(negedge clk);
            check($sformatf("rnd%0d_transfer", it), 32'(fc_valid[d]), 32'd0);
            fc_model[d] = nxt;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
